// File: rtl/reg32_ad_new.sv
// reg32_ad_new: 16 x 32-bit register file with one synchronous write port and one registered read port.
module reg32_ad_new #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_line,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] read_line,
    output logic [DATA_W-1:0] data_out
);
    localparam int DEPTH = 2 ** ADDR_W;
    logic [DATA_W-1:0] mem [DEPTH];
    // Non-blocking update gives read-before-write on a same-line collision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            data_out <= '0;
        end else begin
            if (write_en) mem[write_line] <= data_in;
            if (read_en) data_out <= mem[read_line];
        end
    end
endmodule

// File: tb/tb_reg32_ad_new.sv
// tb_reg32_ad_new: randomized and directed scoreboard bench for reg32_ad_new.
module tb_reg32_ad_new;
    logic        clk = 0;
    logic        reset_n = 0;
    logic        write_en = 0;
    logic [3:0]  write_line = 0;
    logic [31:0] data_in = 0;
    logic        read_en = 0;
    logic [3:0]  read_line = 0;
    logic [31:0] data_out;

    reg32_ad_new dut (
        .clk(clk), .reset_n(reset_n), .write_en(write_en), .write_line(write_line),
        .data_in(data_in), .read_en(read_en), .read_line(read_line), .data_out(data_out)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] exp; string tag; } item_t;
    item_t       sb[$];
    logic [31:0] model [16];
    logic [31:0] last_out;
    bit          chk_hold = 0;
    bit          take;
    int          vectors = 0;
    int          miscompares = 0;

    // Monitor: whenever the DUT samples a read (or a hold check is due), pop and compare.
    always @(posedge clk) begin
        take = (read_en || chk_hold) && reset_n;
        #1;
        if (take) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_empty: data_out=%h with no expected entry", data_out);
            end else begin
                item_t it;
                it = sb.pop_front();
                if (data_out !== it.exp) begin
                    miscompares++;
                    $display("FAIL %s: got %h expected %h", it.tag, data_out, it.exp);
                end
            end
        end
    end

    task automatic check_now(input string tag, input logic [31:0] exp);
        vectors++;
        if (data_out !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, data_out, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        last_out = 32'h0;
    endtask

    task automatic cyc(input logic we, input logic [3:0] wl, input logic [31:0] di,
                       input logic re, input logic [3:0] rl, input bit hold, input string tag);
        @(negedge clk);
        write_en = we; write_line = wl; data_in = di;
        read_en = re; read_line = rl;
        chk_hold = hold && !re;
        if (re) begin
            sb.push_back('{model[rl], tag});
            last_out = model[rl];
        end else if (hold) begin
            sb.push_back('{last_out, tag});
        end
        if (we) model[wl] = di;
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < 16; i++) cyc(0, 4'(i), 32'h0, 1, 4'(i), 0, tag);
    endtask

    initial begin
        clear_model();
        #12;
        check_now("reset_out", 32'h0);
        #10 reset_n = 1;
        read_all_zero("reset_read");

        for (int i = 0; i < 16; i++) begin
            cyc(1, 4'(i), 32'h0000_F0FF, 0, 0, 0, "sweep_wr");
            cyc(0, 0, 32'h0, 1, 4'(i), 0, "sweep_rd");
            cyc(0, 0, 32'h0, 0, 4'(15 - i), 1, "sweep_hold");
        end

        for (int i = 0; i < 16; i++) cyc(1, 4'(i), 32'hA5A5_0000 | i, 0, 0, 0, "uniq_wr");
        for (int i = 15; i >= 0; i--) cyc(0, 0, 32'h0, 1, 4'(i), 0, "uniq_rd");

        cyc(1, 4'd3, 32'h1111_1111, 0, 0, 0, "coll_pre");
        cyc(1, 4'd3, 32'h2222_2222, 1, 4'd3, 0, "coll_old");
        cyc(0, 0, 32'h0, 1, 4'd3, 0, "coll_new");

        for (int i = 0; i < 5; i++) cyc(0, 4'($urandom), $urandom, 0, 0, 0, "nowr");
        for (int i = 0; i < 16; i++) cyc(0, 0, 32'h0, 1, 4'(i), 0, "nowr_rd");
        for (int i = 0; i < 5; i++) cyc(0, 0, 32'h0, 0, 4'($urandom), 1, "rdline_hold");

        cyc(1, 4'd5, 32'hDEAD_BEEF, 0, 0, 0, "ar_wr");
        cyc(0, 0, 32'h0, 1, 4'd5, 0, "ar_rd");
        cyc(0, 0, 32'h0, 0, 0, 0, "ar_idle");
        @(posedge clk);
        #3 reset_n = 0;
        #1 check_now("async_reset_out", 32'h0);
        reset_n = 1;
        clear_model();
        read_all_zero("post_reset_read");

        for (int n = 0; n < 400; n++) begin
            logic re;
            re = 1'($urandom);
            cyc(1'($urandom), 4'($urandom), $urandom, re, 4'($urandom), !re && 1'($urandom), "random");
        end

        cyc(0, 0, 32'h0, 0, 0, 0, "drain");
        cyc(0, 0, 32'h0, 0, 0, 0, "drain");
        @(posedge clk);
        #2;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover: %0d entries remaining expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/reg32_ad_new.md
Name: reg32_ad_new

Overview:
- 16-entry x 32-bit addressable register file with one synchronous write port and one registered read port.
- Used as a small general-purpose storage block. A producer writes a line by address; a consumer later reads that line through a held output register.
- Both ports share one clock and one asynchronous active-low reset.

Parameters:
- DATA_W, 32, width of each register line and of data_in/data_out
- ADDR_W, 4, width of write_line/read_line; DEPTH = 2**ADDR_W = 16 lines

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- write_en  input  1  write strobe, sampled at posedge clk
- write_line  input  ADDR_W  line index to write
- data_in  input  DATA_W  write data
- read_en  input  1  read strobe, sampled at posedge clk
- read_line  input  ADDR_W  line index to read
- data_out  output  DATA_W  registered read data

Behaviour:
- Reset: clk and reset are one clock and an asynchronous, active-low reset.
  - While reset_n=0, all 16 lines and data_out are forced to 0 immediately, independent of clk.
  - Writes and reads are ignored while reset_n=0.
  - On deassertion, normal operation starts at the next rising edge.
- Write: at posedge clk with reset_n=1 and write_en=1, mem[write_line] <= data_in.
  - New contents are visible to a read sampled at the following edge or later.
  - write_en=0: no line changes.
- Read: at posedge clk with reset_n=1 and read_en=1, data_out <= mem[read_line].
  - Latency is 1 clock from the sampling edge to data_out.
  - read_en=0: data_out holds its last value indefinitely. It is not cleared, and it does not track read_line.
- Same-edge write and read to the same line: data_out receives the OLD contents (read-before-write, no bypass). The new value is readable from the next edge.
- Same-edge write and read to different lines: both take effect independently.
- Addressing: all 16 indices 0..15 are valid. There is no out-of-range case, since index bits above ADDR_W do not exist at the port.
- Only full-width writes are supported; there are no byte enables.
- Reset mid-operation: any write or read sampled in the same cycle reset_n falls is lost. Contents return to 0.
- No X propagation from unwritten lines: after reset every line reads 0.
- Inputs are assumed synchronous to clk; the block does no input synchronization.

Test Plan:
- Reset: hold reset_n=0 for 20 ns, release, then read lines 0..15 -> data_out=32'h0000_0000 for every line.
- Write/read sweep: for i=0..15, write data_in=32'h0000_F0FF to line i, then assert read_en with read_line=i for one edge, then deassert read_en.
  - Required: data_out == 32'h0000_F0FF one edge after the read.
  - Required: data_out still equals it on the following edge (hold).
- Address uniqueness: write line i with 32'hA5A5_0000|i for all i, then read in reverse order.
  - Required: each data_out equals its own pattern, confirming no aliasing.
- Collision: line 3 holds 32'h1111_1111. On one edge, write 32'h2222_2222 to line 3 and read line 3.
  - Required: data_out=32'h1111_1111.
  - Required: the next read of line 3 gives 32'h2222_2222.
- Hold/no-write: with write_en=0, toggle data_in and write_line for 5 cycles, then read.
  - Required: contents unchanged.
  - Required: with read_en=0, changing read_line leaves data_out unchanged.
- Async reset: with data_out=32'hDEAD_BEEF, pulse reset_n low between clock edges.
  - Required: data_out=0 before the next posedge.
  - Required: all lines read 0 afterwards.
